// File: rtl/digits_scan_ctrl_if.sv
// Bus between the display front end and its user: conversion request/handshake
// plus the scanned digit outputs that feed the shared 7-seg decoder.
interface digits_scan_ctrl_if;
    logic [9:0] value;
    logic       load;
    logic       busy;
    logic       done;
    logic [2:0] len;
    logic [3:0] sel;
    logic [3:0] digit;
    logic       blank;

    modport master (
        output value, load,
        input  busy, done, len, sel, digit, blank
    );

    modport slave (
        input  value, load,
        output busy, done, len, sel, digit, blank
    );
endinterface

// File: rtl/digits_scan_ctrl.sv
// Binary-to-BCD by repeated subtraction, committed to display registers and
// scanned one digit at a time with leading-zero blanking.
module digits_scan_ctrl #(
    parameter int SCAN_DIV = 16
) (
    input  logic               clk,
    input  logic               reset,
    digits_scan_ctrl_if.slave  bus
);

    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [1:0] {IDLE, S1000, S100, S10} state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [9:0]      r_rem;
    logic [3:0]      r_c1000;
    logic [3:0]      r_c100;
    logic [3:0]      r_c10;
    logic            r_busy;
    logic            r_done;
    logic [3:0][3:0] r_disp;
    logic [2:0]      r_len;
    logic [PW-1:0]   r_presc;
    logic [1:0]      r_pos;

    logic            w_ge1000;
    logic            w_ge100;
    logic            w_ge10;
    logic [2:0]      w_len;

    assign w_ge1000 = (r_rem >= 10'd1000);
    assign w_ge100  = (r_rem >= 10'd100);
    assign w_ge10   = (r_rem >= 10'd10);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    // NOTE: the default assignment first keeps every path driven, so no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (bus.load)  w_next_state = S1000;
            S1000:   if (!w_ge1000) w_next_state = S100;
            S100:    if (!w_ge100)  w_next_state = S10;
            S10:     if (!w_ge10)   w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        if (r_c1000 != 4'd0)     w_len = 3'd4;
        else if (r_c100 != 4'd0) w_len = 3'd3;
        else if (r_c10 != 4'd0)  w_len = 3'd2;
        else                     w_len = 3'd1;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    // NOTE: the display registers are tiny and reset explicitly, so a reset mid-conversion shows a clean 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rem   <= '0;
            r_c1000 <= '0;
            r_c100  <= '0;
            r_c10   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_disp  <= '0;
            r_len   <= 3'd1;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.load) begin
                        r_rem   <= bus.value;
                        r_c1000 <= '0;
                        r_c100  <= '0;
                        r_c10   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                S1000: begin
                    if (w_ge1000) begin
                        r_rem   <= r_rem - 10'd1000;
                        r_c1000 <= r_c1000 + 4'd1;
                    end
                end
                S100: begin
                    if (w_ge100) begin
                        r_rem  <= r_rem - 10'd100;
                        r_c100 <= r_c100 + 4'd1;
                    end
                end
                S10: begin
                    if (w_ge10) begin
                        r_rem <= r_rem - 10'd10;
                        r_c10 <= r_c10 + 4'd1;
                    end else begin
                        r_disp <= {r_c1000, r_c100, r_c10, r_rem[3:0]};
                        r_len  <= w_len;
                        r_done <= 1'b1;
                        r_busy <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Scan timing is free-running and never waits on the converter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc <= '0;
            r_pos   <= 2'd0;
        end else if (r_presc == PW'(SCAN_DIV - 1)) begin
            r_presc <= '0;
            r_pos   <= r_pos + 2'd1;
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    always_comb begin
        bus.busy  = r_busy;
        bus.done  = r_done;
        bus.len   = r_len;
        bus.sel   = 4'b0001 << r_pos;
        bus.digit = r_disp[r_pos];
        bus.blank = ({1'b0, r_pos} >= r_len);
    end

endmodule
